// File: rtl/mips_core_pkg.sv
// Shared types and sizing for the post-commit store drain buffer.
package mips_core_pkg;

  localparam int SDB_W     = 4;
  localparam int SDB_DEPTH = 8;
  localparam int SDB_PTR_W = $clog2(SDB_DEPTH) + 1;
  localparam int SDB_AW    = 32;
  localparam int SDB_DW    = 32;

  typedef struct packed {
    logic [SDB_AW-1:0] addr;
    logic [SDB_DW-1:0] data;
    logic [3:0]        be;
  } sdb_entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } sdb_state_e;

endpackage

// File: rtl/sdb_fwd_search.sv
// Age-ordered store-to-load match over the live buffer entries; youngest match wins.
// Instantiated by store_drain_buffer only when STORE_FWD_EN is defined.
module sdb_fwd_search
  import mips_core_pkg::*;
#(
  parameter int DEPTH = SDB_DEPTH
) (
  input  sdb_entry_t                i_entries [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]  i_head_idx,
  input  logic [$clog2(DEPTH):0]    i_occ,
  input  logic [SDB_AW-3:0]         i_ld_word,
  output logic                      o_hit,
  output logic                      o_stall,
  output logic [SDB_DW-1:0]         o_data
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [IW-1:0] w_idx [DEPTH];

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      w_idx[k] = i_head_idx + IW'(k);
    end
  end

  // Walk oldest to youngest so the last match assigned is the youngest one.
  always_comb begin
    o_hit   = 1'b0;
    o_stall = 1'b0;
    o_data  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((PW'(k) < i_occ) && (i_entries[w_idx[k]].addr[SDB_AW-1:2] == i_ld_word)) begin
        if (i_entries[w_idx[k]].be == 4'hF) begin
          o_hit   = 1'b1;
          o_stall = 1'b0;
          o_data  = i_entries[w_idx[k]].data;
        end else begin
          o_hit   = 1'b0;
          o_stall = 1'b1;
          o_data  = '0;
        end
      end
    end
  end

endmodule

// File: rtl/store_drain_buffer.sv
// Post-commit store buffer: queues up to W retired stores per cycle, drains one per D-cache handshake.
// Optional store-to-load forwarding lookup enabled by defining STORE_FWD_EN.
//
// state | meaning
// IDLE  | no request on the D-cache port
// ISSUE | head entry presented, held stable until dc_req_ready
module store_drain_buffer
  import mips_core_pkg::*;
#(
  parameter int W     = SDB_W,
  parameter int DEPTH = SDB_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [W-1:0]             st_valid,
  input  logic [W*SDB_AW-1:0]      st_addr,
  input  logic [W*SDB_DW-1:0]      st_data,
  input  logic [W*4-1:0]           st_be,
  output logic                     accept,
  output logic                     dc_req_valid,
  output logic [SDB_AW-1:0]        dc_req_addr,
  output logic [SDB_DW-1:0]        dc_req_data,
  output logic [3:0]               dc_req_be,
  input  logic                     dc_req_ready,
  input  logic                     drain_req,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   occupancy,
  input  logic [SDB_AW-1:0]        ld_addr,
  output logic                     fwd_hit,
  output logic [SDB_DW-1:0]        fwd_data,
  output logic                     fwd_stall
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  sdb_entry_t    r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  sdb_state_e    r_state;

  logic [PW-1:0] w_occ;
  logic [PW-1:0] w_push_n;
  logic [PW-1:0] w_push_cnt;
  logic [PW-1:0] w_occ_next;
  logic          w_pop;
  logic [IW-1:0] w_wr_idx [W];
  sdb_entry_t    w_head_entry;

  assign w_occ = r_tail - r_head;

  always_comb begin
    w_push_n = '0;
    for (int i = 0; i < W; i++) begin
      w_push_n = w_push_n + PW'(st_valid[i]);
    end
  end

  always_comb begin
    for (int i = 0; i < W; i++) begin
      w_wr_idx[i] = r_tail[IW-1:0] + IW'(i);
    end
  end

  // Credit check ignores a same-cycle pop, so accept can lag one cycle behind a drain.
  assign accept     = !drain_req && (w_occ <= PW'(DEPTH - W));
  assign w_push_cnt = accept ? w_push_n : '0;
  assign w_pop      = (r_state == ISSUE) && dc_req_ready;
  assign w_occ_next = w_occ + w_push_cnt - PW'(w_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_state <= IDLE;
    end else begin
      r_tail <= r_tail + w_push_cnt;
      if (w_pop) begin
        r_head <= r_head + PW'(1);
      end
      case (r_state)
        IDLE:    if (w_occ_next != '0) r_state <= ISSUE;
        ISSUE:   if (w_pop && (w_occ_next == '0)) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && accept) begin
      for (int i = 0; i < W; i++) begin
        if (st_valid[i]) begin
          r_mem[w_wr_idx[i]] <= '{addr: st_addr[i*SDB_AW +: SDB_AW],
                                  data: st_data[i*SDB_DW +: SDB_DW],
                                  be:   st_be[i*4 +: 4]};
        end
      end
    end
  end

  assign w_head_entry = r_mem[r_head[IW-1:0]];
  assign dc_req_valid = (r_state == ISSUE);
  assign dc_req_addr  = w_head_entry.addr;
  assign dc_req_data  = w_head_entry.data;
  assign dc_req_be    = w_head_entry.be;
  assign occupancy    = w_occ;
  assign empty        = (w_occ == '0) && (r_state == IDLE);

`ifdef STORE_FWD_EN
  sdb_fwd_search #(
    .DEPTH (DEPTH)
  ) u_fwd_search (
    .i_entries  (r_mem),
    .i_head_idx (r_head[IW-1:0]),
    .i_occ      (w_occ),
    .i_ld_word  (ld_addr[SDB_AW-1:2]),
    .o_hit      (fwd_hit),
    .o_stall    (fwd_stall),
    .o_data     (fwd_data)
  );
`else
  logic w_unused_ld;
  assign w_unused_ld = ^ld_addr;
  assign fwd_hit     = 1'b0;
  assign fwd_stall   = 1'b0;
  assign fwd_data    = '0;
`endif

  a_no_push_without_accept: assert property (@(posedge clk) disable iff (!rst_n)
    !((st_valid != '0) && !accept));

endmodule

// File: tb/tb_store_drain_buffer.sv
// Directed and randomized bench for store_drain_buffer against a queue-based reference model.
module tb_store_drain_buffer;
  import mips_core_pkg::*;

  localparam int W     = 4;
  localparam int DEPTH = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   st_valid;
  logic [127:0] st_addr;
  logic [127:0] st_data;
  logic [15:0]  st_be;
  logic         accept;
  logic         dc_req_valid;
  logic [31:0]  dc_req_addr;
  logic [31:0]  dc_req_data;
  logic [3:0]   dc_req_be;
  logic         dc_req_ready;
  logic         drain_req;
  logic         empty;
  logic [3:0]   occupancy;
  logic [31:0]  ld_addr;
  logic         fwd_hit;
  logic [31:0]  fwd_data;
  logic         fwd_stall;

  always #5 clk = ~clk;

  store_drain_buffer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .st_valid     (st_valid),
    .st_addr      (st_addr),
    .st_data      (st_data),
    .st_be        (st_be),
    .accept       (accept),
    .dc_req_valid (dc_req_valid),
    .dc_req_addr  (dc_req_addr),
    .dc_req_data  (dc_req_data),
    .dc_req_be    (dc_req_be),
    .dc_req_ready (dc_req_ready),
    .drain_req    (drain_req),
    .empty        (empty),
    .occupancy    (occupancy),
    .ld_addr      (ld_addr),
    .fwd_hit      (fwd_hit),
    .fwd_data     (fwd_data),
    .fwd_stall    (fwd_stall)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } ent_t;

  ent_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_accept(input logic drn);
    return !drn && ((DEPTH - q.size()) >= W);
  endfunction

  task automatic model_fwd(output logic h, output logic s, output logic [31:0] dd);
    h  = 1'b0;
    s  = 1'b0;
    dd = '0;
`ifdef STORE_FWD_EN
    for (int k = q.size() - 1; k >= 0; k--) begin
      if (q[k].addr[31:2] == ld_addr[31:2]) begin
        if (q[k].be == 4'hF) begin
          h  = 1'b1;
          dd = q[k].data;
        end else begin
          s = 1'b1;
        end
        break;
      end
    end
`endif
  endtask

  task automatic check_outputs(input logic drn);
    logic        eh, es;
    logic [31:0] ed;
    check("occupancy", 64'(occupancy), 64'(q.size()));
    check("accept", 64'(accept), 64'(m_accept(drn)));
    check("empty", 64'(empty), 64'(q.size() == 0));
    check("dc_req_valid", 64'(dc_req_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      check("dc_req_addr", 64'(dc_req_addr), 64'(q[0].addr));
      check("dc_req_data", 64'(dc_req_data), 64'(q[0].data));
      check("dc_req_be", 64'(dc_req_be), 64'(q[0].be));
    end
    model_fwd(eh, es, ed);
    check("fwd_hit", 64'(fwd_hit), 64'(eh));
    check("fwd_stall", 64'(fwd_stall), 64'(es));
    check("fwd_data", 64'(fwd_data), 64'(ed));
  endtask

  // One cycle: drive at negedge, check, then advance the model across the posedge.
  task automatic step(input logic [3:0] v, input logic [127:0] a, input logic [127:0] d,
                      input logic [15:0] b, input logic rdy, input logic drn);
    bit   acc, pop;
    ent_t e;
    if (!m_accept(drn)) v = '0;
    st_valid     = v;
    st_addr      = a;
    st_data      = d;
    st_be        = b;
    dc_req_ready = rdy;
    drain_req    = drn;
    #1;
    check_outputs(drn);
    acc = m_accept(drn);
    pop = (q.size() != 0) && rdy;
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (acc) begin
      for (int i = 0; i < W; i++) begin
        if (v[i]) begin
          e.addr = a[i*32 +: 32];
          e.data = d[i*32 +: 32];
          e.be   = b[i*4 +: 4];
          q.push_back(e);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic push_grp(input int n, input logic [31:0] base, input logic [31:0] dbase,
                          input logic [3:0] be, input logic rdy, input logic drn);
    logic [127:0] a, d;
    logic [15:0]  b;
    logic [3:0]   v;
    a = '0; d = '0; b = '0; v = '0;
    for (int i = 0; i < n; i++) begin
      v[i]          = 1'b1;
      a[i*32 +: 32] = base + 32'(4 * i);
      d[i*32 +: 32] = dbase + 32'(i);
      b[i*4 +: 4]   = be;
    end
    step(v, a, d, b, rdy, drn);
  endtask

  task automatic idle(input int n, input logic rdy, input logic drn);
    repeat (n) step('0, '0, '0, '0, rdy, drn);
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    st_valid     = '0;
    dc_req_ready = 1'b0;
    drain_req    = 1'b0;
    @(posedge clk);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_dc_req_valid", 64'(dc_req_valid), 64'd0);
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_accept", 64'(accept), 64'd1);
    check("rst_fwd_hit", 64'(fwd_hit), 64'd0);
    check("rst_fwd_stall", 64'(fwd_stall), 64'd0);
  endtask

  initial begin
    logic [127:0] ra, rd;
    logic [15:0]  rb;
    logic [3:0]   rv;
    int           rn;

    rst_n = 1'b0; st_valid = '0; st_addr = '0; st_data = '0; st_be = '0;
    dc_req_ready = 1'b0; drain_req = 1'b0; ld_addr = '0;
    @(negedge clk);
    do_reset();

    // Burst of four with the cache always ready
    push_grp(4, 32'h100, 32'hD000, 4'hF, 1'b1, 1'b0);
    check("burst_first_valid", 64'(dc_req_valid), 64'd1);
    check("burst_first_addr", 64'(dc_req_addr), 64'h100);
    idle(5, 1'b1, 1'b0);
    check("burst_empty", 64'(empty), 64'd1);

    // Fill to capacity under backpressure, then partially drain
    push_grp(4, 32'h100, 32'hE000, 4'hF, 1'b0, 1'b0);
    push_grp(4, 32'h110, 32'hE010, 4'hF, 1'b0, 1'b0);
    idle(2, 1'b0, 1'b0);
    check("full_occupancy", 64'(occupancy), 64'd8);
    check("full_accept", 64'(accept), 64'd0);
    check("full_head_addr", 64'(dc_req_addr), 64'h100);
    idle(4, 1'b1, 1'b0);
    check("half_occupancy", 64'(occupancy), 64'd4);
    check("half_accept", 64'(accept), 64'd1);
    idle(5, 1'b1, 1'b0);

    // Wrap: tail lands at 3, then a group splits across index 7 -> 0
    do_reset();
    push_grp(3, 32'h300, 32'h3000, 4'hF, 1'b0, 1'b0);
    idle(4, 1'b1, 1'b0);
    push_grp(4, 32'h400, 32'h4000, 4'hF, 1'b0, 1'b0);
    push_grp(3, 32'h500, 32'h5000, 4'hF, 1'b0, 1'b0);
    check("wrap_occupancy", 64'(occupancy), 64'd7);
    idle(10, 1'b1, 1'b0);
    check("wrap_empty", 64'(empty), 64'd1);

    // Simultaneous push and pop, then drain with enqueue blocked
    do_reset();
    push_grp(2, 32'h600, 32'h6000, 4'hF, 1'b0, 1'b0);
    push_grp(2, 32'h700, 32'h7000, 4'hF, 1'b1, 1'b0);
    check("simul_occupancy", 64'(occupancy), 64'd3);
    idle(6, 1'b1, 1'b1);
    check("drain_accept", 64'(accept), 64'd0);
    check("drain_empty", 64'(empty), 64'd1);

    // Reset while a request is held mid-handshake
    push_grp(4, 32'h800, 32'h8000, 4'hF, 1'b0, 1'b0);
    push_grp(1, 32'h810, 32'h8010, 4'hF, 1'b0, 1'b0);
    check("pre_rst_occupancy", 64'(occupancy), 64'd5);
    check("pre_rst_valid", 64'(dc_req_valid), 64'd1);
    do_reset();

    // Forwarding lookup: youngest full match, then a younger partial match
    push_grp(1, 32'h200, 32'hAA, 4'hF, 1'b0, 1'b0);
    push_grp(1, 32'h200, 32'hBB, 4'hF, 1'b0, 1'b0);
    ld_addr = 32'h200;
    #1;
`ifdef STORE_FWD_EN
    check("fwd_full_hit", 64'(fwd_hit), 64'd1);
    check("fwd_full_data", 64'(fwd_data), 64'hBB);
`else
    check("fwd_off_hit", 64'(fwd_hit), 64'd0);
`endif
    idle(1, 1'b0, 1'b0);
    push_grp(1, 32'h200, 32'hCC, 4'h3, 1'b0, 1'b0);
    #1;
`ifdef STORE_FWD_EN
    check("fwd_partial_stall", 64'(fwd_stall), 64'd1);
    check("fwd_partial_hit", 64'(fwd_hit), 64'd0);
`else
    check("fwd_off_stall", 64'(fwd_stall), 64'd0);
`endif
    idle(6, 1'b1, 1'b0);
    do_reset();

    // Randomized traffic
    for (int t = 0; t < 400; t++) begin
      rn = $urandom_range(0, 4);
      rv = '0; ra = '0; rd = '0; rb = '0;
      for (int i = 0; i < rn; i++) begin
        rv[i]          = 1'b1;
        ra[i*32 +: 32] = 32'h200 + 32'(4 * $urandom_range(0, 7));
        rd[i*32 +: 32] = $urandom;
        rb[i*4 +: 4]   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      end
      ld_addr = 32'h200 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      step(rv, ra, rd, rb, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 9) == 0));
    end
    idle(12, 1'b1, 1'b0);
    check("final_empty", 64'(empty), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/store_drain_buffer.md
Name: store_drain_buffer

Overview:
- Post-commit store buffer sitting directly downstream of commit and the store queue.
- Each cycle, commit hands over up to W retired stores (address, data, byte enables), compacted into slots 0..n-1.
- The buffer queues them in program order and drains one per accepted D-cache request over a valid/ready handshake.
- Committed stores are architectural: they are never squashed by branch misses. Only reset clears them.

Parameters:
- W, 4 (`COMMIT_WINDOW_SIZE`): max stores accepted per cycle.
- DEPTH, 8: buffer entries; power of 2, DEPTH >= 2*W.
- AW, 32: address width (word aligned; bits [1:0] ignored).
- DW, 32 (`DATA_WIDTH`): data width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- st_valid  in  W  per-slot valid; contiguous from slot 0 (1111, 0111, 0011, 0001, 0000 only)
- st_addr  in  W*AW  slot i at [i*AW +: AW]
- st_data  in  W*DW  slot i at [i*DW +: DW]
- st_be  in  W*4  byte enables per slot
- accept  out  1  buffer can take W stores this cycle; commit holds stores while low
- dc_req_valid  out  1  D-cache write request
- dc_req_addr  out  AW  head address
- dc_req_data  out  DW  head data
- dc_req_be  out  4  head byte enables
- dc_req_ready  in  1  D-cache accepts request
- drain_req  in  1  drain before halt/syscall; blocks enqueue
- empty  out  1  no entries and no request outstanding
- occupancy  out  $clog2(DEPTH)+1  current entry count
- ld_addr  in  AW  forwarding lookup (STORE_FWD_EN only)
- fwd_hit  out  1  full-word match found
- fwd_data  out  DW  forwarded data
- fwd_stall  out  1  partial-byte match; load must wait

Behaviour:
- Reset: rst_n is synchronous, active-low; clock is clk. On reset, head=tail=0 with wrap bits 0, state=IDLE, dc_req_valid=0, accept=1, empty=1, occupancy=0, fwd_*=0. All entries are discarded, including a request held mid-handshake; dc_req_valid is 0 on the cycle after reset.
- Pointers: head and tail are $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
  - occupancy = tail - head, mod 2^(log2 DEPTH + 1).
  - full when the index bits are equal and the wrap bits differ.
- accept = !drain_req && (DEPTH - occupancy) >= W.
  - Uses registered occupancy only; a same-cycle pop is not credited (conservative).
- Enqueue: n = popcount(st_valid).
  - If accept, slot i is written to entry (tail+i) mod DEPTH, and tail += n.
  - st_valid != 0 while accept = 0 is a protocol violation: SVA error, and the write is ignored.
- Drain FSM:
  - IDLE: dc_req_valid=0. Goes to ISSUE when occupancy != 0 at a clock edge. Minimum enqueue-to-request latency is 1 cycle.
  - ISSUE: dc_req_valid=1, head entry driven. Addr/data/be are held stable until dc_req_ready.
    - On valid && ready: head++. Go to IDLE if the post-pop occupancy is 0, else stay in ISSUE (back-to-back, 1 store/cycle).
- Simultaneous push and pop in one cycle: both are applied, occupancy += n-1.
  - A push into an empty buffer while in IDLE is not bypassed to dc_req in the same cycle.
- Wrap-around: pointer arithmetic is mod 2^(log2 DEPTH + 1); the index is the low bits, so slot writes wrap mid-group.
- empty = (occupancy==0) && state==IDLE.
- drain_req: blocks accept, draining continues. The pipeline waits for empty.

Optional Feature:
- Macro STORE_FWD_EN.
- When defined:
  - Combinational search of all valid entries, youngest to oldest, for addr[AW-1:2]==ld_addr[AW-1:2].
  - Youngest match with be==4'hF gives fwd_hit=1 and fwd_data = that entry's data.
  - Youngest match with a partial be gives fwd_stall=1, fwd_hit=0.
  - No match gives both 0.
  - The entry in ISSUE still counts as valid until popped.
- When undefined: fwd_hit=0, fwd_stall=0, fwd_data=0; ld_addr is unused.

Decomposition:
- mips_core_pkg holds:
  - `sdb_entry_t` struct {addr, data, be};
  - `SDB_DEPTH` and `SDB_PTR_W` constants;
  - the `sdb_state_e` enum {IDLE, ISSUE}.
- One sub-module, `sdb_fwd_search`: DEPTH-wide age-ordered match and priority select. It is instantiated only under STORE_FWD_EN.

Test Plan:
- Reset: from 5 entries with ISSUE mid-handshake, assert rst_n=0 for 1 cycle → next cycle dc_req_valid=0, occupancy=0, empty=1, accept=1.
- Burst: st_valid=4'b1111 with addr 0x100..0x10C, dc_req_ready=1 held → requests appear on cycles t+1..t+4 in order 0x100, 0x104, 0x108, 0x10C, then IDLE and empty=1.
- Backpressure/full: 2 groups of 4 with dc_req_ready=0 → occupancy=8, accept=0. Raise ready for 4 cycles → occupancy=4, accept=1. The head stays at 0x100 stable while ready=0.
- Wrap: push 3, drain 3, push 4 (entries 3..6), push 3 (entries 7, 0, 1) → drain order is preserved across index 7→0, and the wrap bit toggles.
- Simultaneous: occupancy=2 in ISSUE, ready=1, st_valid=0011 → next occupancy=3. drain_req=1 → accept=0, and after all pops empty=1.
- STORE_FWD_EN: entries 0x200/be=F/data=0xAA then 0x200/be=F/data=0xBB; ld_addr=0x200 → fwd_hit=1, fwd_data=0xBB. A younger 0x200/be=3 → fwd_stall=1, fwd_hit=0.
